keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4-row x 3-column matrix keypad, debounces the result and drives the 4-bit `key` code consumed by the alarm-clock control FSM. `key` carries a digit code 0-9 while a key is held and debounced, and NOKEY (4'hF) otherwise. A one-cycle `key_valid` strobe accompanies each new debounced press. The block sits between the keypad pins and the clock controller, in the `clock` domain.

## Interface
- SCAN_DIV, 1000: clocks per column slot; legal range is 4 or more.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release; legal range is 2 to 15.
- clock  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active-low (externally pulled up), asynchronous to `clock`.
- col  out  3  column drive, one-hot active-low.
- key  out  4  debounced key code. 0-9 = digit; 4'hF = NOKEY.
- key_valid  out  1  one-clock pulse when `key` changes to a digit.

## Operation
- **Synchronizer:** `row` passes through 2 flops (reset value 4'hF) before any use.
- **Slot divider:** `div` counts 0..SCAN_DIV-1 and wraps. `slot_end` = (div == SCAN_DIV-1).
- **Column select:** `col_sel` counts 0..2 and advances at each `slot_end`, wrapping 2 -> 0. `col` = ~(3'b001 << col_sel).
- **Row sampling:** at `slot_end`, the synchronized rows are sampled for the current column. A hit is a row bit at 0.
- **Frame:** one frame is columns 0, 1, 2. `frame_end` = `slot_end` with col_sel == 2, and it includes that slot's sample.
- **Key map (row r, col c):**
  - Rows 0-2 give digit 3r+c+1 (1-9).
  - Row 3, col 1 gives 0.
  - Row 3, cols 0 and 2 (*, #) are unmapped.
- **frame_code:**
  - Exactly one hit in the frame on a mapped key gives that key's code.
  - Zero hits, two or more hits (ghosting or multiple keys), or a single unmapped hit give 4'hF.
- **Debounce FSM:** `state`, candidate `cand[3:0]`, counter `cnt[3:0]`. Evaluated only at `frame_end`.
  - **IDLE** (key = F): frame_code != F -> PRESS_DB, cand = frame_code, cnt = 1.
  - **PRESS_DB:**
    - frame_code == cand -> cnt += 1. If cnt reaches DEBOUNCE -> HELD, key = cand, key_valid = 1 for one clock.
    - frame_code == F -> IDLE.
    - Other digit -> cand = frame_code, cnt = 1.
  - **HELD** (key = cand): frame_code == cand -> stay. Anything else -> RELEASE_DB, cnt = 1.
  - **RELEASE_DB:**
    - frame_code == key -> HELD (bounce absorbed, no new key_valid).
    - Otherwise cnt += 1. If cnt reaches DEBOUNCE -> IDLE, key = F.
    - A different digit held through release is accepted only after passing through IDLE and PRESS_DB.
- **Widths:** `cnt` never exceeds DEBOUNCE. `div` is sized to $clog2(SCAN_DIV).

## Timing
- **Reset values:** key = 4'hF, key_valid = 0, col = 3'b110, col_sel = 0, div = 0, state = IDLE, cand = F, cnt = 0, synchronizer = 4'hF.
- **Reset mid-scan or mid-debounce:** everything returns immediately to the reset values. After reset release, the next slot starts at div = 0.
- **Frame period:** 3*SCAN_DIV clocks.
- **Press latency:** a clean press first seen in frame k appears on `key` (and `key_valid`) one clock after the `frame_end` of frame k+DEBOUNCE-1.
- **Release latency:** a release first seen in frame k returns `key` to F one clock after the `frame_end` of frame k+DEBOUNCE-1.
- **Registered outputs:**
  - `key` and `key_valid` are registered and change only in the clock after a `frame_end`.
  - `key` is stable for at least DEBOUNCE frames between changes.
- **Sampling margin:** the 2-cycle synchronizer latency is absorbed because sampling is at slot end and SCAN_DIV is at least 4.
- **Unsupported input:** a row edge inside a slot shorter than 2 clocks may be missed; this is not required to be caught.

## Test plan
All cases use SCAN_DIV = 4, DEBOUNCE = 3; the keypad model pulls `row` low when the pressed key's column is driven low.
- **Clean press and release:** press digit 5 (row 1, col 1), hold 10 frames, release.
  - `key` = 4'h5 and key_valid pulses once, one clock after the 3rd `frame_end`.
  - `key` returns to F one clock after the 3rd frame with no hit.
- **Bouncing press:** toggle row 3 col 1 (digit 0) on alternate frames for 6 frames, then hold.
  - `key` stays F during toggling.
  - `key` becomes 0 after 3 stable frames, with exactly one key_valid.
- **Multiple and unmapped keys:** hold digits 1 and 2 together, then '*' alone, each for 6 frames.
  - `key` stays F throughout; key_valid is never asserted.
- **Release bounce:** hold digit 9, then drop it for 1 frame and restore.
  - `key` stays 9 with no second key_valid.
- **Key change:** hold digit 3, then switch directly to digit 7.
  - `key` goes 3 -> F after 3 frames, then F -> 7 after 3 more frames.
  - Exactly one key_valid for each of 3 and 7.
- **Reset mid-operation:** assert reset low mid-slot while in HELD with key = 4.
  - `key` = F, `col` = 3'b110 and key_valid = 0 immediately, before the next clock edge.
  - Scanning restarts from col 0 after release.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad pins and the debounced key output of keypad_scanner.
//   row        keypad rows, active-low, asynchronous to the scanner clock
//   col        column drive, one-hot active-low
//   key        debounced key code, 0-9 digit or 4'hF for no key
//   key_valid  one-clock strobe on each new debounced digit
// Modports:
//   slave   the scanner itself (reads rows, drives columns and key outputs)
//   master  the surrounding keypad/controller side
interface keypad_scanner_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       key_valid;

  modport slave (input row, output col, output key, output key_valid);
  modport master (output row, input col, input key, input key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4-row x 3-column matrix keypad one column at a time, builds a
// per-frame key code and debounces it into a registered key/key_valid pair.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   kp     keypad_scanner_if.slave (row in, col/key/key_valid out)
// Parameters:
//   SCAN_DIV  clocks per column slot (>= 4)
//   DEBOUNCE  identical frames needed to accept a press or release (2..15)
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.slave  kp
);

  localparam int          DIV_W = $clog2(SCAN_DIV);
  localparam logic [3:0]  NOKEY = 4'hF;
  localparam logic [3:0]  DB_N  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_sel;
  logic [3:0]       hit_col0;
  logic [3:0]       hit_col1;
  logic             slot_end;
  logic             frame_end;
  logic [11:0]      frame_hits;
  logic [3:0]       hit_count;
  logic [3:0]       last_code;
  logic [3:0]       frame_code;
  state_t           state;
  logic [3:0]       cand;
  logic [3:0]       cnt;
  logic [3:0]       key_r;
  logic             key_valid_r;

  assign slot_end  = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (col_sel == 2'd2);
  assign kp.col       = ~(3'b001 << col_sel);
  assign kp.key       = key_r;
  assign kp.key_valid = key_valid_r;

  // Two-flop synchronizer for the asynchronous row inputs; idles high
  // (no key) out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  // Slot divider and column selector. Each column is driven for SCAN_DIV
  // clocks, so the synchronized rows have settled by the slot's last clock.
  // Column 0 and 1 hits are kept until the frame closes on column 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      col_sel  <= 2'd0;
      hit_col0 <= 4'h0;
      hit_col1 <= 4'h0;
    end else begin
      if (slot_end) begin
        div     <= '0;
        col_sel <= (col_sel == 2'd2) ? 2'd0 : col_sel + 2'd1;
        if (col_sel == 2'd0) hit_col0 <= ~row_sync;
        if (col_sel == 2'd1) hit_col1 <= ~row_sync;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Frame code: the column 2 sample is taken live at frame_end so the last
  // slot counts in the same frame. Only a single hit on a mapped key yields
  // a digit; ghosting, multiple keys, '*' and '#' all collapse to NOKEY.
  always_comb begin
    frame_hits = {~row_sync, hit_col1, hit_col0};
    hit_count  = 4'd0;
    last_code  = NOKEY;
    frame_code = NOKEY;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (frame_hits[c*4 + r]) begin
          hit_count = hit_count + 4'd1;
          if (r < 3)
            last_code = 4'(3*r + c + 1);
          else if (c == 1)
            last_code = 4'd0;
          else
            last_code = NOKEY;
        end
      end
    end
    if (hit_count == 4'd1) frame_code = last_code;
  end

  // Debounce FSM, stepped once per frame. A press must repeat the same digit
  // DEBOUNCE frames in a row; a release must show DEBOUNCE frames without the
  // held digit, and the held digit reappearing mid-release returns to HELD
  // without a new strobe. A different digit during release still counts as
  // release, so it must debounce from IDLE on its own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cand        <= NOKEY;
      cnt         <= 4'd0;
      key_r       <= NOKEY;
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_code != NOKEY) begin
              state <= PRESS_DB;
              cand  <= frame_code;
              cnt   <= 4'd1;
            end
          end
          PRESS_DB: begin
            if (frame_code == cand) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DB_N) begin
                state       <= HELD;
                key_r       <= cand;
                key_valid_r <= 1'b1;
              end
            end else if (frame_code == NOKEY) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else begin
              cand <= frame_code;
              cnt  <= 4'd1;
            end
          end
          HELD: begin
            if (frame_code != cand) begin
              state <= RELEASE_DB;
              cnt   <= 4'd1;
            end
          end
          RELEASE_DB: begin
            if (frame_code == key_r) begin
              state <= HELD;
            end else begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DB_N) begin
                state <= IDLE;
                key_r <= NOKEY;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Scoreboard bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE = 3
// (one frame = 12 clocks). Stimulus is applied on frame boundaries; each
// expected key change (value and the clock count at which it must appear)
// is queued, and a monitor pops and compares on every observed key change.
module tb_keypad_scanner;

  localparam int FRAME = 12;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [11:0] pressed;
  logic [3:0]  row_model;
  int          cyc;
  int          frame_no;
  int          tests;
  int          fails;
  int          exp_valid;
  int          valid_seen;
  logic [3:0]  prev_key;
  exp_t        exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock),
    .reset(reset),
    .kp(kif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clock counter aligned with the DUT: zero under reset, so frame n ends on
  // the posedge that brings cyc to 12n.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad model: a pressed key (bit r*3+c) pulls its row low while its
  // column is driven low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !kif.col[c]) row_model[r] = 1'b0;
  end
  assign kif.row = row_model;

  function automatic logic [11:0] keyBit(input int r, input int c);
    logic [11:0] one;
    one = 12'd1;
    return one << (r*3 + c);
  endfunction

  task automatic expectKey(input logic [3:0] code, input int frame);
    exp_t e;
    e.code = code;
    e.cyc  = FRAME * frame;
    exp_q.push_back(e);
    if (code != 4'hF) exp_valid++;
  endtask

  task automatic applyStimulus(input logic [11:0] keys, input int frames);
    pressed = keys;
    repeat (frames * FRAME) @(negedge clock);
    frame_no += frames;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every change of key must match the head of the scoreboard in
  // value and timing, with key_valid high exactly when the new key is a digit.
  always @(negedge clock) begin
    if (!reset) begin
      prev_key = 4'hF;
    end else begin
      if (kif.key_valid) valid_seen++;
      if (kif.key !== prev_key) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL key_change: unexpected key=%h at cyc=%0d", kif.key, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (kif.key !== e.code || cyc != e.cyc || kif.key_valid !== (e.code != 4'hF)) begin
            fails++;
            $display("[TB] FAIL key_change: got key=%h valid=%b cyc=%0d, expected key=%h valid=%b cyc=%0d",
                     kif.key, kif.key_valid, cyc, e.code, (e.code != 4'hF), e.cyc);
          end
        end
        prev_key = kif.key;
      end else if (kif.key_valid) begin
        tests++;
        fails++;
        $display("[TB] FAIL stray_valid: key_valid=1 with unchanged key=%h at cyc=%0d, expected 0", kif.key, cyc);
      end
    end
  end

  initial begin
    int s;
    int t;
    tests      = 0;
    fails      = 0;
    exp_valid  = 0;
    valid_seen = 0;
    frame_no   = 0;
    prev_key   = 4'hF;
    pressed    = 12'd0;
    reset      = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_key", kif.key, 4'hF);
    checkOutput("reset_valid", {3'd0, kif.key_valid}, 4'd0);
    checkOutput("reset_col", {1'b0, kif.col}, 4'b0110);
    reset = 1'b1;

    // Clean press of 5, held 10 frames, then released.
    s = frame_no + 1;
    expectKey(4'h5, s + 2);
    applyStimulus(keyBit(1, 1), 10);
    expectKey(4'hF, s + 12);
    applyStimulus(12'd0, 5);

    // Digit 0 bouncing on alternate frames, then held and released.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(keyBit(3, 1), 1);
      applyStimulus(12'd0, 1);
    end
    s = frame_no + 1;
    expectKey(4'h0, s + 2);
    applyStimulus(keyBit(3, 1), 6);
    expectKey(4'hF, s + 8);
    applyStimulus(12'd0, 5);

    // Two keys together, then '*' alone: never a key.
    applyStimulus(keyBit(0, 0) | keyBit(0, 1), 6);
    applyStimulus(keyBit(3, 0), 6);
    applyStimulus(12'd0, 2);

    // Digit 9 with a one-frame dropout during hold.
    s = frame_no + 1;
    expectKey(4'h9, s + 2);
    applyStimulus(keyBit(2, 2), 6);
    applyStimulus(12'd0, 1);
    applyStimulus(keyBit(2, 2), 4);
    t = frame_no + 1;
    expectKey(4'hF, t + 2);
    applyStimulus(12'd0, 5);

    // Direct switch from 3 to 7.
    s = frame_no + 1;
    expectKey(4'h3, s + 2);
    applyStimulus(keyBit(0, 2), 6);
    t = frame_no + 1;
    expectKey(4'hF, t + 2);
    expectKey(4'h7, t + 5);
    applyStimulus(keyBit(2, 0), 8);
    t = frame_no + 1;
    expectKey(4'hF, t + 2);
    applyStimulus(12'd0, 5);

    // Reset mid-slot while holding 4; outputs must clear before any edge.
    s = frame_no + 1;
    expectKey(4'h4, s + 2);
    applyStimulus(keyBit(1, 0), 4);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_key", kif.key, 4'hF);
    checkOutput("midreset_col", {1'b0, kif.col}, 4'b0110);
    checkOutput("midreset_valid", {3'd0, kif.key_valid}, 4'd0);
    repeat (3) @(negedge clock);
    checkOutput("inreset_col", {1'b0, kif.col}, 4'b0110);
    checkOutput("inreset_key", kif.key, 4'hF);
    frame_no = 0;
    expectKey(4'h4, 3);
    reset = 1'b1;
    checkOutput("restart_col0", {1'b0, kif.col}, 4'b0110);
    repeat (4) @(negedge clock);
    checkOutput("restart_col1", {1'b0, kif.col}, 4'b0101);
    repeat (4) @(negedge clock);
    checkOutput("restart_col2", {1'b0, kif.col}, 4'b0011);
    repeat (4) @(negedge clock);
    checkOutput("restart_wrap", {1'b0, kif.col}, 4'b0110);
    frame_no = 1;
    applyStimulus(keyBit(1, 0), 3);
    t = frame_no + 1;
    expectKey(4'hF, t + 2);
    applyStimulus(12'd0, 5);

    // Everything queued must have been seen, with one strobe per digit.
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending: %0d key changes never seen, expected 0", exp_q.size());
    end
    tests++;
    if (valid_seen != exp_valid) begin
      fails++;
      $display("[TB] FAIL valid_count: got %0d pulses, expected %0d", valid_seen, exp_valid);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
